// File: rtl/perf_pkg.sv
// +----------------------------------------------------------------------------+
// | perf_pkg : shared types and constants for the performance counter bank     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } perf_state_e;

  localparam int IDX_W  = 5;
  localparam int MAX_CH = 16;

endpackage

`default_nettype wire

// File: rtl/perf_ctr.sv
// +----------------------------------------------------------------------------+
// | perf_ctr : single event counter with clear, increment, wrap/saturate mode  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module perf_ctr #(
  parameter int CNT_W = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             all_ones;

  assign all_ones = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (SAT && all_ones) cnt_d = cnt_q;
      else                 cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // The next value is exported so the shadow capture includes the final cycle.
  assign cnt_d_o = cnt_d;
  assign ovf_o   = inc_i & ~clr_i & all_ones;

endmodule

`default_nettype wire

// File: rtl/perf_counter_bank.sv
// +----------------------------------------------------------------------------+
// | perf_counter_bank : NUM_CH event counters plus a cycle counter, captured   |
// | on halt/stop and drained as valid/ready records. Optional sticky overflow  |
// | flags when PERF_OVF_FLAGS_EN is defined.                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter bit SAT    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              halt,
  input  logic [NUM_CH-1:0] ev,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CNT_W-1:0]  out_data,
  output logic              busy,
  output logic              done
`ifdef PERF_OVF_FLAGS_EN
  ,
  output logic [NUM_CH:0]   ovf
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);

  perf_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_CH:0][CNT_W-1:0] shadow_q;
  logic [NUM_CH:0][CNT_W-1:0] ctr_nxt;
  logic [NUM_CH:0]          ovf_pulse;
  logic [NUM_CH:0]          inc;
  logic                     run;
  logic                     clr;
  logic                     capture;

  assign run = (state_q == ST_RUN);
  // Top bit is the cycle counter, which ticks every RUN cycle.
  assign inc = {run, ev & {NUM_CH{run}}};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt || stop) begin
          state_d = ST_DRAIN;
          capture = 1'b1;
          idx_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_ctr
    perf_ctr #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .inc_i   (inc[g]),
      .cnt_d_o (ctr_nxt[g]),
      .ovf_o   (ovf_pulse[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         shadow_q <= '0;
    else if (capture) shadow_q <= ctr_nxt;
  end

  always_comb begin
    out_data = '0;
    if (state_q == ST_DRAIN) begin
      for (int i = 0; i <= NUM_CH; i++) begin
        if (idx_q == IDX_W'(i)) out_data = shadow_q[i];
      end
    end
  end

  assign out_valid = (state_q == ST_DRAIN);
  assign out_idx   = idx_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

`ifdef PERF_OVF_FLAGS_EN
  logic [NUM_CH:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (clr) ovf_d = '0;
    else     ovf_d = ovf_q | ovf_pulse;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= '0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf_pulse;
`endif

endmodule

`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
// +----------------------------------------------------------------------------+
// | tb_perf_counter_bank : randomized self-checking bench for the counter bank |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_perf_counter_bank;

  localparam int NCH = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, stop, halt, out_ready;
  logic [NCH-1:0] ev;

  logic           valid_a, valid_b, valid_c;
  logic [4:0]     idx_a, idx_b, idx_c;
  logic [31:0]    data_a;
  logic [7:0]     data_b, data_c;
  logic           busy_a, busy_b, busy_c;
  logic           done_a, done_b, done_c;
`ifdef PERF_OVF_FLAGS_EN
  logic [NCH:0]   ovf_a, ovf_b, ovf_c;
`endif

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(32), .SAT(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .halt(halt), .ev(ev),
    .out_valid(valid_a), .out_ready(out_ready), .out_idx(idx_a), .out_data(data_a),
    .busy(busy_a), .done(done_a)
`ifdef PERF_OVF_FLAGS_EN
    , .ovf(ovf_a)
`endif
  );

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .SAT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .halt(halt), .ev(ev),
    .out_valid(valid_b), .out_ready(out_ready), .out_idx(idx_b), .out_data(data_b),
    .busy(busy_b), .done(done_b)
`ifdef PERF_OVF_FLAGS_EN
    , .ovf(ovf_b)
`endif
  );

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .SAT(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .halt(halt), .ev(ev),
    .out_valid(valid_c), .out_ready(out_ready), .out_idx(idx_c), .out_data(data_c),
    .busy(busy_c), .done(done_c)
`ifdef PERF_OVF_FLAGS_EN
    , .ovf(ovf_c)
`endif
  );

  int     n_chk  = 0;
  int     n_pass = 0;
  longint cnt [0:NCH];   // true event totals; index NCH is the cycle count

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_w32(input longint v);
    return 64'(v % 64'h1_0000_0000);
  endfunction

  function automatic logic [63:0] exp_w8(input longint v);
    return 64'(v % 256);
  endfunction

  function automatic logic [63:0] exp_s8(input longint v);
    return (v > 255) ? 64'd255 : 64'(v);
  endfunction

  function automatic logic [63:0] exp_ovf(input longint lim);
    logic [63:0] r = '0;
    for (int i = 0; i <= NCH; i++) r[i] = (cnt[i] >= lim);
    return r;
  endfunction

  task automatic check_status(input string tag, input bit b, input bit d, input bit v);
    check_eq({tag, "_busy"},  64'(busy_a),  64'(b));
    check_eq({tag, "_done"},  64'(done_a),  64'(d));
    check_eq({tag, "_valid"}, 64'(valid_a), 64'(v));
    check_eq({tag, "_lockstep"}, {61'b0, valid_b, valid_c, busy_c}, {61'b0, v, v, b});
  endtask

  task automatic check_ovf(input string tag);
`ifdef PERF_OVF_FLAGS_EN
    check_eq({tag, "_ovf_a"}, 64'(ovf_a), exp_ovf(64'h1_0000_0000));
    check_eq({tag, "_ovf_b"}, 64'(ovf_b), exp_ovf(256));
    check_eq({tag, "_ovf_c"}, 64'(ovf_c), exp_ovf(256));
`else
    check_eq({tag, "_no_ovf_busy"}, 64'(busy_b), 64'(busy_a));
`endif
  endtask

  // mode 0: ev[0] every cycle, ev[3] first 4 cycles; 1: ev[1] every cycle but last; 2: random
  task automatic do_run(input int ncyc, input int mode, input bit end_stop, input bit start_with_halt);
    for (int i = 0; i <= NCH; i++) cnt[i] = 0;
    start = 1'b1;
    halt  = start_with_halt;
    stop  = 1'b0;
    ev    = NCH'($urandom);
    tick();
    start = 1'b0;
    halt  = 1'b0;
    check_status("run_entry", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= ncyc; k++) begin
      case (mode)
        0:       begin ev = '0; ev[0] = 1'b1; ev[3] = (k <= 4); end
        1:       ev = (k < ncyc) ? NCH'(2) : '0;
        default: ev = NCH'($urandom);
      endcase
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      halt  = (k == ncyc) && !end_stop;
      stop  = (k == ncyc) && end_stop;
      for (int i = 0; i < NCH; i++) cnt[i] += longint'(ev[i]);
      cnt[NCH]++;
      tick();
    end
    start = 1'b0;
    halt  = 1'b0;
    stop  = 1'b0;
    ev    = '0;
  endtask

  // rmode 0: ready high; 1: toggle 1/0; 2: random. abort_after > 0 resets after that many accepts.
  task automatic do_drain(input int rmode, input int abort_after);
    int e = 0;
    int acc = 0;
    int budget = 0;
    while (e <= NCH && budget < 200) begin
      budget++;
      check_eq("rec_valid", 64'(valid_a), 64'd1);
      check_eq("rec_idx",   64'(idx_a),   64'(e));
      check_eq("rec_data32", 64'(data_a), exp_w32(cnt[e]));
      check_eq("rec_data8w", 64'(data_b), exp_w8(cnt[e]));
      check_eq("rec_data8s", 64'(data_c), exp_s8(cnt[e]));
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (budget % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      ev = NCH'($urandom);
      tick();
      if (out_ready) begin
        e++;
        acc++;
        if (abort_after > 0 && acc == abort_after) begin
          out_ready = 1'b0;
          rst = 1'b0;
          #1;
          check_status("rst_async", 1'b0, 1'b0, 1'b0);
          check_eq("rst_idx",  64'(idx_a),  64'd0);
          check_eq("rst_data", 64'(data_a), 64'd0);
          for (int i = 0; i <= NCH; i++) cnt[i] = 0;
          check_ovf("rst");
          @(negedge clk);
          rst = 1'b1;
          ev  = '0;
          tick();
          check_status("rst_idle", 1'b0, 1'b0, 1'b0);
          return;
        end
      end
    end
    if (e <= NCH) check_eq("drain_timeout", 64'(e), 64'(NCH + 1));
    out_ready = 1'b0;
    ev        = '0;
    check_status("drain_end", 1'b0, 1'b1, 1'b0);
    tick();
    check_status("done_hold", 1'b0, 1'b1, 1'b0);
    check_ovf("done");
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    halt      = 1'b0;
    out_ready = 1'b0;
    ev        = '0;
    for (int i = 0; i <= NCH; i++) cnt[i] = 0;
    repeat (3) tick();
    check_status("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset_idx",  64'(idx_a),  64'd0);
    check_eq("reset_data", 64'(data_a), 64'd0);
    check_ovf("reset");
    @(negedge clk);
    rst = 1'b1;

    // Idle ignores everything except start.
    for (int k = 0; k < 5; k++) begin
      ev   = NCH'($urandom);
      halt = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1));
      tick();
    end
    halt = 1'b0;
    stop = 1'b0;
    ev   = '0;
    check_status("idle_noise", 1'b0, 1'b0, 1'b0);

    do_run(10, 0, 1'b0, 1'b0);
    do_drain(0, 0);

    do_run(10, 0, 1'b0, 1'b0);
    do_drain(1, 0);

    do_run(301, 1, 1'b1, 1'b0);
    check_eq("wrap_idx1_model", exp_w8(cnt[1]), 64'd44);
    do_drain(2, 0);

    do_run(12, 2, 1'b0, 1'b1);
    do_drain(2, 0);

    for (int r = 0; r < 8; r++) begin
      do_run($urandom_range(1, 40), 2, 1'($urandom_range(0, 1)), 1'b0);
      do_drain($urandom_range(0, 2), 0);
    end

    do_run(15, 2, 1'b0, 1'b0);
    do_drain(0, 3);
    do_run(10, 0, 1'b0, 1'b0);
    do_drain(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
